// File: rtl/axi_slave_mem_if.sv
// Slave-side AXI signal bundle for axi_slave_mem: AW, W, B, AR and R channels with 8-bit IDs.
interface axi_slave_mem_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32
) ();

  logic [7:0]              awid;
  logic [ADD_WIDTH-1:0]    awaddr;
  logic [7:0]              awlen;
  logic [2:0]              awsize;
  logic [1:0]              awburst;
  logic                    awlock;
  logic                    awvalid;
  logic                    awready;

  logic [7:0]              wid;
  logic [DATA_WIDTH-1:0]   wdata;
  logic [DATA_WIDTH/8-1:0] wstrb;
  logic                    wlast;
  logic                    wvalid;
  logic                    wready;

  logic [7:0]              bid;
  logic [1:0]              bresp;
  logic                    bvalid;
  logic                    bready;

  logic [7:0]              arid;
  logic [ADD_WIDTH-1:0]    araddr;
  logic [7:0]              arlen;
  logic [2:0]              arsize;
  logic [1:0]              arburst;
  logic                    arlock;
  logic                    arvalid;
  logic                    arready;

  logic [7:0]              rid;
  logic [DATA_WIDTH-1:0]   rdata;
  logic [1:0]              rresp;
  logic                    rlast;
  logic                    rvalid;
  logic                    rready;

  modport slave (
    input  awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
    output awready,
    input  wid, wdata, wstrb, wlast, wvalid,
    output wready,
    output bid, bresp, bvalid,
    input  bready,
    input  arid, araddr, arlen, arsize, arburst, arlock, arvalid,
    output arready,
    output rid, rdata, rresp, rlast, rvalid,
    input  rready
  );

  modport master (
    output awid, awaddr, awlen, awsize, awburst, awlock, awvalid,
    input  awready,
    output wid, wdata, wstrb, wlast, wvalid,
    input  wready,
    input  bid, bresp, bvalid,
    output bready,
    output arid, araddr, arlen, arsize, arburst, arlock, arvalid,
    input  arready,
    input  rid, rdata, rresp, rlast, rvalid,
    output rready
  );

endinterface

// File: rtl/axi_slave_mem.sv
// AXI slave memory: one write burst and one read burst in flight at a time on independent
// FSMs, backed by a word array with byte strobes.
module axi_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADD_WIDTH  = 32,
  parameter int MEM_DEPTH  = 1024
) (
  input logic            aclk,
  input logic            areset,
  axi_slave_mem_if.slave bus
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int OFFS   = $clog2(STRB_W);
  localparam int IDXW   = $clog2(MEM_DEPTH);
  localparam logic [2:0]           MAX_SIZE = 3'(OFFS);
  localparam logic [ADD_WIDTH-1:0] ADDR_ONE = ADD_WIDTH'(1);
  localparam logic [1:0]           RESP_OKAY   = 2'b00;
  localparam logic [1:0]           RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wState_t;
  typedef enum logic {R_IDLE, R_DATA} rState_t;

  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  function automatic logic [IDXW-1:0] wordIdx(input logic [ADD_WIDTH-1:0] addr);
    return addr[OFFS +: IDXW];
  endfunction

  // Address of the beat after 'addr'; WRAP uses a power-of-two block, so masking replaces compare.
  function automatic logic [ADD_WIDTH-1:0] nextAddr(input logic [ADD_WIDTH-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [7:0] len,
                                                    input logic [1:0] burst);
    logic [ADD_WIDTH-1:0] bytes, aligned, incr, wrapBytes, wrapMask;
    bytes     = ADDR_ONE << size;
    aligned   = addr & ~(bytes - ADDR_ONE);
    incr      = aligned + bytes;
    wrapBytes = ADD_WIDTH'({1'b0, len} + 9'd1) << size;
    wrapMask  = wrapBytes - ADDR_ONE;
    case (burst)
      2'b01:   return incr;
      2'b10:   return (addr & ~wrapMask) | (incr & wrapMask);
      default: return addr;
    endcase
  endfunction

  function automatic logic burstErr(input logic [2:0] size, input logic [7:0] len,
                                    input logic [1:0] burst);
    logic wrapLenOk;
    wrapLenOk = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
    return (size > MAX_SIZE) || (burst == 2'b11) || ((burst == 2'b10) && !wrapLenOk);
  endfunction

  wState_t              wState_q, wState_d;
  logic [ADD_WIDTH-1:0] wAddr_q, wAddr_d;
  logic [7:0]           awId_q, awId_d;
  logic [7:0]           awLen_q, awLen_d;
  logic [2:0]           awSize_q, awSize_d;
  logic [1:0]           awBurst_q, awBurst_d;
  logic [7:0]           wBeat_q, wBeat_d;
  logic                 wErr_q, wErr_d;
  logic                 wLastErr_q, wLastErr_d;
  logic [7:0]           bid_q, bid_d;
  logic [1:0]           bresp_q, bresp_d;

  rState_t               rState_q, rState_d;
  logic [ADD_WIDTH-1:0]  rAddr_q, rAddr_d;
  logic [7:0]            arLen_q, arLen_d;
  logic [2:0]            arSize_q, arSize_d;
  logic [1:0]            arBurst_q, arBurst_d;
  logic [7:0]            rBeat_q, rBeat_d;
  logic                  rErr_q, rErr_d;
  logic                  rvalid_q, rvalid_d;
  logic                  rlast_q, rlast_d;
  logic [7:0]            rid_q, rid_d;
  logic [1:0]            rresp_q, rresp_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

  logic                  memWe;
  logic                  wLastBeat;
  logic                  wlastBad;
  logic [ADD_WIDTH-1:0]  rNextAddr;
  logic                  unusedInputs;

  assign wLastBeat    = (wBeat_q == awLen_q);
  assign wlastBad     = (bus.wlast != wLastBeat);
  assign rNextAddr    = nextAddr(rAddr_q, arSize_q, arLen_q, arBurst_q);
  assign unusedInputs = ^{bus.wid, bus.awlock, bus.arlock};

  assign bus.awready = (wState_q == W_IDLE);
  assign bus.wready  = (wState_q == W_DATA);
  assign bus.bvalid  = (wState_q == W_RESP);
  assign bus.bid     = bid_q;
  assign bus.bresp   = bresp_q;
  assign bus.arready = (rState_q == R_IDLE);
  assign bus.rvalid  = rvalid_q;
  assign bus.rlast   = rlast_q;
  assign bus.rid     = rid_q;
  assign bus.rresp   = rresp_q;
  assign bus.rdata   = rdata_q;

  always_ff @(posedge aclk or negedge areset) begin
    if (!areset) begin
      wState_q   <= W_IDLE;
      wAddr_q    <= '0;
      awId_q     <= '0;
      awLen_q    <= '0;
      awSize_q   <= '0;
      awBurst_q  <= '0;
      wBeat_q    <= '0;
      wErr_q     <= 1'b0;
      wLastErr_q <= 1'b0;
      bid_q      <= '0;
      bresp_q    <= RESP_OKAY;
      rState_q   <= R_IDLE;
      rAddr_q    <= '0;
      arLen_q    <= '0;
      arSize_q   <= '0;
      arBurst_q  <= '0;
      rBeat_q    <= '0;
      rErr_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      rlast_q    <= 1'b0;
      rid_q      <= '0;
      rresp_q    <= RESP_OKAY;
      rdata_q    <= '0;
    end else begin
      wState_q   <= wState_d;
      wAddr_q    <= wAddr_d;
      awId_q     <= awId_d;
      awLen_q    <= awLen_d;
      awSize_q   <= awSize_d;
      awBurst_q  <= awBurst_d;
      wBeat_q    <= wBeat_d;
      wErr_q     <= wErr_d;
      wLastErr_q <= wLastErr_d;
      bid_q      <= bid_d;
      bresp_q    <= bresp_d;
      rState_q   <= rState_d;
      rAddr_q    <= rAddr_d;
      arLen_q    <= arLen_d;
      arSize_q   <= arSize_d;
      arBurst_q  <= arBurst_d;
      rBeat_q    <= rBeat_d;
      rErr_q     <= rErr_d;
      rvalid_q   <= rvalid_d;
      rlast_q    <= rlast_d;
      rid_q      <= rid_d;
      rresp_q    <= rresp_d;
      rdata_q    <= rdata_d;
    end
  end

  // Memory has no reset; byte lanes are written only for non-erroneous bursts.
  always_ff @(posedge aclk) begin
    for (int b = 0; b < STRB_W; b++) begin
      if (memWe && bus.wstrb[b]) begin
        mem[wordIdx(wAddr_q)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
      end
    end
  end

  always_comb begin
    wState_d   = wState_q;
    wAddr_d    = wAddr_q;
    awId_d     = awId_q;
    awLen_d    = awLen_q;
    awSize_d   = awSize_q;
    awBurst_d  = awBurst_q;
    wBeat_d    = wBeat_q;
    wErr_d     = wErr_q;
    wLastErr_d = wLastErr_q;
    bid_d      = bid_q;
    bresp_d    = bresp_q;
    memWe      = 1'b0;
    case (wState_q)
      W_IDLE: begin
        if (bus.awvalid) begin
          wAddr_d    = bus.awaddr;
          awId_d     = bus.awid;
          awLen_d    = bus.awlen;
          awSize_d   = bus.awsize;
          awBurst_d  = bus.awburst;
          wErr_d     = burstErr(bus.awsize, bus.awlen, bus.awburst);
          wBeat_d    = '0;
          wLastErr_d = 1'b0;
          wState_d   = W_DATA;
        end
      end
      W_DATA: begin
        if (bus.wvalid) begin
          memWe = !wErr_q;
          if (wLastBeat) begin
            bid_d    = awId_q;
            bresp_d  = (wErr_q || wLastErr_q || wlastBad) ? RESP_SLVERR : RESP_OKAY;
            wState_d = W_RESP;
          end else begin
            wLastErr_d = wLastErr_q || wlastBad;
            wAddr_d    = nextAddr(wAddr_q, awSize_q, awLen_q, awBurst_q);
            wBeat_d    = wBeat_q + 8'd1;
          end
        end
      end
      W_RESP: begin
        if (bus.bready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Each presented beat is fetched from the array when the previous one is accepted.
  always_comb begin
    rState_d  = rState_q;
    rAddr_d   = rAddr_q;
    arLen_d   = arLen_q;
    arSize_d  = arSize_q;
    arBurst_d = arBurst_q;
    rBeat_d   = rBeat_q;
    rErr_d    = rErr_q;
    rvalid_d  = rvalid_q;
    rlast_d   = rlast_q;
    rid_d     = rid_q;
    rresp_d   = rresp_q;
    rdata_d   = rdata_q;
    case (rState_q)
      R_IDLE: begin
        if (bus.arvalid) begin
          rAddr_d   = bus.araddr;
          arLen_d   = bus.arlen;
          arSize_d  = bus.arsize;
          arBurst_d = bus.arburst;
          rErr_d    = burstErr(bus.arsize, bus.arlen, bus.arburst);
          rBeat_d   = '0;
          rvalid_d  = 1'b1;
          rlast_d   = (bus.arlen == 8'd0);
          rid_d     = bus.arid;
          rresp_d   = rErr_d ? RESP_SLVERR : RESP_OKAY;
          rdata_d   = rErr_d ? '0 : mem[wordIdx(bus.araddr)];
          rState_d  = R_DATA;
        end
      end
      R_DATA: begin
        if (bus.rready) begin
          if (rlast_q) begin
            rvalid_d = 1'b0;
            rlast_d  = 1'b0;
            rState_d = R_IDLE;
          end else begin
            rAddr_d = rNextAddr;
            rBeat_d = rBeat_q + 8'd1;
            rlast_d = ((rBeat_q + 8'd1) == arLen_q);
            rdata_d = rErr_q ? '0 : mem[wordIdx(rNextAddr)];
          end
        end
      end
      default: rState_d = R_IDLE;
    endcase
  end

endmodule

// File: tb/tb_axi_slave_mem.sv
// Randomized scoreboard bench for axi_slave_mem: a byte-level memory model predicts B and R
// responses, and a negedge monitor compares them against what the DUT presents.
module tb_axi_slave_mem;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 1024;

  typedef struct packed {
    logic [7:0] id;
    logic [1:0] resp;
  } bExp_t;

  typedef struct packed {
    logic [7:0]  id;
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rExp_t;

  logic aclk = 1'b0;
  logic areset = 1'b0;

  axi_slave_mem_if #(.DATA_WIDTH(DW), .ADD_WIDTH(AW)) bus ();

  axi_slave_mem #(.DATA_WIDTH(DW), .ADD_WIDTH(AW), .MEM_DEPTH(DEPTH)) dut (
    .aclk  (aclk),
    .areset(areset),
    .bus   (bus)
  );

  always #5 aclk = ~aclk;

  bExp_t       expB [$];
  rExp_t       expR [$];
  logic [31:0] refMem [DEPTH];
  logic [31:0] txData [256];
  logic [3:0]  txStrb [256];
  logic        txLast [256];

  int   vecCount = 0;
  int   missCount = 0;
  bit   monEnable = 1'b0;
  bit   gapMode = 1'b0;
  int   readyMode = 2;
  logic bReadyManual = 1'b0;
  logic rReadyManual = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    vecCount++;
    if (actual !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, actual, expected, $time);
    end
  endtask

  task automatic failNow(input string name);
    vecCount++;
    missCount++;
    $display("[TB] FAIL %s: bound expired at %0t", name, $time);
  endtask

  function automatic bit modelErr(input logic [2:0] size, input logic [7:0] len,
                                  input logic [1:0] burst);
    return (size > 3'd2) || (burst == 2'b11) ||
           ((burst == 2'b10) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}));
  endfunction

  // Word index of beat 'beat' computed directly from the burst start.
  function automatic int modelIndex(input logic [31:0] addr, input logic [2:0] size,
                                    input logic [7:0] len, input logic [1:0] burst,
                                    input int beat);
    bit [31:0] bytes, start, a, wb, base;
    bytes = 32'd1 << size;
    start = addr & ~(bytes - 32'd1);
    case (burst)
      2'b01: a = (beat == 0) ? addr : start + bytes * 32'(beat);
      2'b10: begin
        wb   = bytes * (32'(len) + 32'd1);
        base = addr & ~(wb - 32'd1);
        a    = base + ((start - base + bytes * 32'(beat)) % wb);
      end
      default: a = addr;
    endcase
    return int'((a >> 2) % DEPTH);
  endfunction

  always @(posedge aclk) begin
    #1;
    case (readyMode)
      0: begin
        bus.bready = 1'b1;
        bus.rready = 1'b1;
      end
      1: begin
        bus.bready = 1'($urandom_range(0, 1));
        bus.rready = 1'($urandom_range(0, 1));
      end
      default: begin
        bus.bready = bReadyManual;
        bus.rready = rReadyManual;
      end
    endcase
  end

  bExp_t       bE;
  rExp_t       rE;
  bit          bHold = 1'b0;
  bit          rHold = 1'b0;
  logic [63:0] bHoldVal, rHoldVal;

  // Monitor: pops the scoreboard on every accepted response and checks held payloads stay put.
  always @(negedge aclk) begin
    if (!monEnable) begin
      bHold = 1'b0;
      rHold = 1'b0;
    end else begin
      if (bHold) checkOutput("bHeld", 64'({bus.bvalid, bus.bid, bus.bresp}), bHoldVal);
      bHold = 1'b0;
      if (bus.bvalid) begin
        if (bus.bready) begin
          if (expB.size() == 0) failNow("bUnexpected");
          else begin
            bE = expB.pop_front();
            checkOutput("bid", 64'(bus.bid), 64'(bE.id));
            checkOutput("bresp", 64'(bus.bresp), 64'(bE.resp));
          end
        end else begin
          bHold    = 1'b1;
          bHoldVal = 64'({1'b1, bus.bid, bus.bresp});
        end
      end
      if (rHold) checkOutput("rHeld",
                             64'({bus.rvalid, bus.rid, bus.rdata, bus.rresp, bus.rlast}), rHoldVal);
      rHold = 1'b0;
      if (bus.rvalid) begin
        if (bus.rready) begin
          if (expR.size() == 0) failNow("rUnexpected");
          else begin
            rE = expR.pop_front();
            checkOutput("rid", 64'(bus.rid), 64'(rE.id));
            checkOutput("rdata", 64'(bus.rdata), 64'(rE.data));
            checkOutput("rresp", 64'(bus.rresp), 64'(rE.resp));
            checkOutput("rlast", 64'(bus.rlast), 64'(rE.last));
          end
        end else begin
          rHold    = 1'b1;
          rHoldVal = 64'({1'b1, bus.rid, bus.rdata, bus.rresp, bus.rlast});
        end
      end
    end
  end

  task automatic waitHandshake(input int which);
    int cnt = 0;
    forever begin
      @(negedge aclk);
      if ((which == 0 && bus.awready) || (which == 1 && bus.wready) ||
          (which == 2 && bus.arready)) break;
      cnt++;
      if (cnt > 3000) begin
        failNow("handshakeTimeout");
        break;
      end
    end
  endtask

  task automatic waitDrain();
    int cnt = 0;
    while ((expB.size() != 0 || expR.size() != 0) && cnt < 5000) begin
      @(posedge aclk);
      cnt++;
    end
    if (expB.size() != 0 || expR.size() != 0) failNow("drainTimeout");
  endtask

  // Write beats come from txData/txStrb/txLast; the model is updated when the burst is issued.
  task automatic applyStimulus(input bit isWrite, input logic [7:0] id, input logic [31:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    bit    err, mismatch;
    int    idx;
    bExp_t be;
    rExp_t re;
    err = modelErr(size, len, burst);
    if (isWrite) begin
      mismatch = 1'b0;
      for (int i = 0; i <= int'(len); i++)
        if (txLast[i] != (i == int'(len))) mismatch = 1'b1;
      be.id   = id;
      be.resp = (err || mismatch) ? 2'b10 : 2'b00;
      expB.push_back(be);
      if (!err) begin
        for (int i = 0; i <= int'(len); i++) begin
          idx = modelIndex(addr, size, len, burst, i);
          for (int b = 0; b < 4; b++)
            if (txStrb[i][b]) refMem[idx][b*8 +: 8] = txData[i][b*8 +: 8];
        end
      end
      @(posedge aclk); #1;
      bus.awid    = id;
      bus.awaddr  = addr;
      bus.awlen   = len;
      bus.awsize  = size;
      bus.awburst = burst;
      bus.awlock  = 1'($urandom_range(0, 1));
      bus.awvalid = 1'b1;
      waitHandshake(0);
      @(posedge aclk); #1;
      bus.awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
        if (gapMode && $urandom_range(0, 3) == 0) begin
          bus.wvalid = 1'b0;
          @(posedge aclk); #1;
        end
        bus.wid    = 8'($urandom);
        bus.wdata  = txData[i];
        bus.wstrb  = txStrb[i];
        bus.wlast  = txLast[i];
        bus.wvalid = 1'b1;
        waitHandshake(1);
        @(posedge aclk); #1;
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
    end else begin
      for (int i = 0; i <= int'(len); i++) begin
        re.id   = id;
        re.data = err ? 32'h0 : refMem[modelIndex(addr, size, len, burst, i)];
        re.resp = err ? 2'b10 : 2'b00;
        re.last = (i == int'(len));
        expR.push_back(re);
      end
      @(posedge aclk); #1;
      bus.arid    = id;
      bus.araddr  = addr;
      bus.arlen   = len;
      bus.arsize  = size;
      bus.arburst = burst;
      bus.arlock  = 1'($urandom_range(0, 1));
      bus.arvalid = 1'b1;
      waitHandshake(2);
      @(posedge aclk); #1;
      bus.arvalid = 1'b0;
      waitDrain();
    end
  endtask

  task automatic setBurst(input int len, input logic [31:0] base, input logic [31:0] step,
                          input logic [3:0] strb);
    for (int i = 0; i <= len; i++) begin
      txData[i] = base + step * 32'(i);
      txStrb[i] = strb;
      txLast[i] = (i == len);
    end
  endtask

  initial begin
    logic [1:0]  rb;
    logic [7:0]  rl;
    logic [2:0]  rs;
    int          sel;
    for (int i = 0; i < DEPTH; i++) refMem[i] = 32'h0;
    bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0;
    bus.awlock = 1'b0; bus.awvalid = 1'b0;
    bus.wid = '0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
    bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0; bus.arburst = '0;
    bus.arlock = 1'b0; bus.arvalid = 1'b0;

    repeat (2) @(negedge aclk);
    checkOutput("rstAwready", 64'(bus.awready), 64'd1);
    checkOutput("rstArready", 64'(bus.arready), 64'd1);
    checkOutput("rstWready", 64'(bus.wready), 64'd0);
    checkOutput("rstBvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("rstRvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("rstRlast", 64'(bus.rlast), 64'd0);
    checkOutput("rstBidBresp", 64'({bus.bid, bus.bresp}), 64'd0);
    checkOutput("rstRidRresp", 64'({bus.rid, bus.rresp}), 64'd0);
    checkOutput("rstRdata", 64'(bus.rdata), 64'd0);
    areset = 1'b1;

    // Abandon a write and a read mid-burst with an asynchronous reset.
    @(posedge aclk); #1;
    bus.awid = 8'h33; bus.awaddr = 32'h800; bus.awlen = 8'd7; bus.awsize = 3'd2;
    bus.awburst = 2'b01; bus.awvalid = 1'b1;
    bus.arid = 8'h44; bus.araddr = 32'h900; bus.arlen = 8'd7; bus.arsize = 3'd2;
    bus.arburst = 2'b01; bus.arvalid = 1'b1;
    @(posedge aclk); #1;
    bus.awvalid = 1'b0; bus.arvalid = 1'b0;
    bus.wdata = 32'hDEADBEEF; bus.wstrb = 4'hF; bus.wvalid = 1'b1;
    repeat (2) begin
      @(posedge aclk); #1;
    end
    checkOutput("midBurstRvalid", 64'(bus.rvalid), 64'd1);
    checkOutput("midBurstAwready", 64'(bus.awready), 64'd0);
    #2 areset = 1'b0;
    #1;
    checkOutput("asyncAwready", 64'(bus.awready), 64'd1);
    checkOutput("asyncArready", 64'(bus.arready), 64'd1);
    checkOutput("asyncBvalid", 64'(bus.bvalid), 64'd0);
    checkOutput("asyncRvalid", 64'(bus.rvalid), 64'd0);
    checkOutput("asyncRdata", 64'(bus.rdata), 64'd0);
    bus.wvalid = 1'b0;
    @(negedge aclk);
    areset = 1'b1;
    readyMode = 0;
    monEnable = 1'b1;

    // Zero the whole array so the model and DUT start from identical contents.
    setBurst(255, 32'h0, 32'h0, 4'hF);
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 8'(k), 32'(k * 1024), 8'd255, 3'd2, 2'b01);
    waitDrain();

    setBurst(3, 32'h11111111, 32'h11111111, 4'hF);
    applyStimulus(1'b1, 8'h5A, 32'h100, 8'd3, 3'd2, 2'b01);
    applyStimulus(1'b0, 8'h5A, 32'h100, 8'd3, 3'd2, 2'b01);

    readyMode = 2;
    bReadyManual = 1'b0;
    rReadyManual = 1'b0;
    setBurst(0, 32'hAABBCCDD, 32'h0, 4'b0101);
    applyStimulus(1'b1, 8'h21, 32'h300, 8'd0, 3'd2, 2'b01);
    repeat (5) @(posedge aclk);
    bReadyManual = 1'b1;
    waitDrain();
    readyMode = 1;
    applyStimulus(1'b0, 8'h22, 32'h300, 8'd0, 3'd2, 2'b01);
    applyStimulus(1'b0, 8'h23, 32'h100, 8'd3, 3'd2, 2'b01);

    setBurst(3, 32'hA0A0A0A0, 32'h01010101, 4'hF);
    applyStimulus(1'b1, 8'h31, 32'h38, 8'd3, 3'd2, 2'b10);
    applyStimulus(1'b0, 8'h32, 32'h30, 8'd3, 3'd2, 2'b01);

    setBurst(2, 32'd1, 32'd1, 4'hF);
    applyStimulus(1'b1, 8'h41, 32'h200, 8'd2, 3'd2, 2'b00);
    applyStimulus(1'b0, 8'h42, 32'h200, 8'd0, 3'd2, 2'b01);

    setBurst(0, 32'hFFFFFFFF, 32'h0, 4'hF);
    applyStimulus(1'b1, 8'h51, 32'h500, 8'd0, 3'd3, 2'b01);
    applyStimulus(1'b0, 8'h52, 32'h500, 8'd0, 3'd2, 2'b01);
    applyStimulus(1'b0, 8'h53, 32'h100, 8'd1, 3'd2, 2'b11);
    setBurst(2, 32'h12340000, 32'h1, 4'hF);
    txLast[0] = 1'b1;
    applyStimulus(1'b1, 8'h54, 32'h700, 8'd2, 3'd2, 2'b01);
    applyStimulus(1'b0, 8'h55, 32'h700, 8'd2, 3'd2, 2'b01);

    setBurst(7, 32'h5A5A0000, 32'h3, 4'hF);
    fork
      applyStimulus(1'b1, 8'h61, 32'h600, 8'd7, 3'd2, 2'b01);
      applyStimulus(1'b0, 8'h62, 32'hA00, 8'd7, 3'd2, 2'b01);
    join
    waitDrain();

    gapMode = 1'b1;
    for (int n = 0; n < 60; n++) begin
      sel = $urandom_range(0, 9);
      rb  = (sel < 3) ? 2'b00 : (sel < 7) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      rl  = 8'($urandom_range(0, 15));
      if (rb == 2'b10 && $urandom_range(0, 4) != 0) rl = 8'((2 << $urandom_range(0, 3)) - 1);
      rs  = ($urandom_range(0, 9) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 1) == 1) begin
        for (int i = 0; i <= int'(rl); i++) begin
          txData[i] = $urandom;
          txStrb[i] = 4'($urandom_range(0, 15));
          txLast[i] = (i == int'(rl));
        end
        if ($urandom_range(0, 7) == 0) begin
          sel = $urandom_range(0, int'(rl));
          txLast[sel] = ~txLast[sel];
        end
        applyStimulus(1'b1, 8'($urandom), 32'($urandom_range(0, 8191)), rl, rs, rb);
      end else begin
        applyStimulus(1'b0, 8'($urandom), 32'($urandom_range(0, 8191)), rl, rs, rb);
      end
    end
    waitDrain();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/axi_slave_mem.md
Name: axi_slave_mem

Overview:
- AXI slave memory model that answers the slave-side signal set of the AXI slave agent interface: write address, write data, write response, read address and read data channels, each with 8-bit IDs.
- Acts as the DUT-side responder, or as a reference memory, for the slave agent.
- Accepts one write burst and one read burst at a time; the write and read paths are independent.
- Stores data in an internal word array.

Parameters:
- DATA_WIDTH, 32, data bus width in bits; power of two, 8..1024.
- ADD_WIDTH, 32, address width in bits.
- MEM_DEPTH, 1024, number of DATA_WIDTH-bit words; power of two.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-low reset.
- awid/awaddr/awlen/awsize/awburst/awlock/awvalid  in  8/ADD_WIDTH/8/3/2/1/1  write address channel.
- awready  out  1  write address ready.
- wid/wdata/wstrb/wlast/wvalid  in  8/DATA_WIDTH/DATA_WIDTH/8/1/1  write data channel.
- wready  out  1  write data ready.
- bid/bresp/bvalid  out  8/2/1  write response channel.
- bready  in  1  write response ready.
- arid/araddr/arlen/arsize/arburst/arlock/arvalid  in  8/ADD_WIDTH/8/3/2/1/1  read address channel.
- arready  out  1  read address ready.
- rid/rdata/rresp/rlast/rvalid  out  8/DATA_WIDTH/2/1/1  read data channel.
- rready  in  1  read data ready.

Behaviour:
- Reset (areset=0, async):
  - awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0.
  - bid/rid/bresp/rresp/rdata = 0.
  - Both FSMs go to IDLE.
  - Memory contents are not reset (undefined).
  - Reset mid-burst abandons the burst; no response is issued.
- Handshake: a transfer occurs on a rising edge with valid & ready both high. Outputs are registered. Once bvalid/rvalid is asserted, it and its payload hold until accepted.

- Write FSM, W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
  - W_IDLE: awready=1. On the AW handshake, latch id, addr, len, size and burst; go to W_DATA.
  - W_DATA: wready=1, awready=0.
    - Each W handshake writes the bytes of wdata enabled by wstrb to mem[index], then advances the address.
    - The burst ends on beat awlen+1.
  - W_RESP: bvalid=1, bid=latched awid. Asserted the cycle after the final W handshake. Return to W_IDLE on bready.
  - wid is ignored.
  - wlast mismatch: wlast=1 before the final beat, or 0 on the final beat, gives bresp=SLVERR (2'b10). The burst length still follows awlen.
- Read FSM, R_IDLE -> R_DATA -> R_IDLE:
  - R_IDLE: arready=1. On the AR handshake, latch the fields; go to R_DATA.
  - R_DATA: rvalid=1 from the cycle after the AR handshake; rid=latched arid.
    - rdata = mem[index] of the current beat address, read combinationally from the array and held in the output register. A same-cycle write becomes visible on the next presented beat.
    - On each rready handshake, advance; rlast=1 on beat arlen+1.
    - After the last handshake, return to R_IDLE with rvalid=0.
- Address arithmetic (per burst):
  - beat bytes = 2^size.
  - FIXED (00): the address stays constant.
  - INCR (01): addr += 2^size; the address is aligned down to 2^size after the first beat.
  - WRAP (10): wraps within an aligned block of (len+1)*2^size bytes.
  - index = (addr >> log2(DATA_WIDTH/8)) mod MEM_DEPTH; accesses past the array wrap around modulo MEM_DEPTH.
- Errors, giving bresp/rresp = SLVERR for the whole burst:
  - size > log2(DATA_WIDTH/8);
  - burst = 11 (reserved);
  - WRAP with len not in {1,3,7,15}.
  - Erroneous writes do not modify memory. Erroneous reads return rdata=0 on every beat. Beat count and rlast still follow len.
- Otherwise bresp/rresp = OKAY (00). awlock and arlock are ignored (no exclusive monitor; never EXOKAY).
- Simultaneous read and write bursts proceed concurrently. A new AW or AR is accepted only in the IDLE state of its own FSM.

Test Plan:
- Reset: assert areset=0 mid-burst -> awready=1, arready=1, bvalid=0, rvalid=0 immediately; after release the next burst completes normally.
- INCR write/read: AW addr=0x100, len=3, size=2, id=0x5A, data 0x11111111..0x44444444, wstrb=F -> bid=0x5A, bresp=00. AR same address -> 4 beats with identical data, rid=0x5A, rlast only on beat 4.
- Strobe and backpressure: write 0xAABBCCDD with wstrb=0101 over an old value of 0 -> readback 0x00BB00DD. Hold bready=0 for 5 cycles -> bvalid and bid stable. rready toggling -> each beat held until accepted.
- WRAP: addr=0x38, len=3, size=2, write A,B,C,D -> words land at 0x38, 0x3C, 0x30, 0x34. INCR read from 0x30 -> C, D, A, B.
- FIXED: len=2 to addr 0x200 with data 1,2,3 -> read of 0x200 returns 3.
- Errors:
  - size=3 on a 32-bit bus -> bresp=10 and memory unchanged.
  - arburst=11, len=1 -> 2 beats of rresp=10, rdata=0.
  - Early wlast on beat 1 of len=2 -> bresp=10.
